rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writers. Writer A is the in-order pipeline writeback (S3). Writer B is a multi-cycle unit (e.g. mul/div) that returns results out of band.
- Sits between S3 / the multi-cycle unit and the register file write inputs (WriteSelect / WriteData / WriteEnable).
- Gives A fixed priority and holds B in a one-entry buffer. A starvation counter forces a B slot by back-pressuring A.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register select width (32 registers)
- STARVE_LIMIT, 4, consecutive cycles B may wait while held before a forced slot; legal range 1..15

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- A_Valid  input  1  S3 writeback request
- A_Ready  output  1  A request consumed this cycle
- A_WriteSelect  input  ADDR_W  A destination register
- A_WriteData  input  DATA_W  A data
- B_Valid  input  1  multi-cycle unit result valid
- B_Ready  output  1  holding buffer empty; B accepted when B_Valid && B_Ready
- B_WriteSelect  input  ADDR_W  B destination register
- B_WriteData  input  DATA_W  B data
- B_Pending  output  1  buffer occupied (for hazard unit)
- B_PendingSelect  output  ADDR_W  destination held in buffer; 0 when empty
- RF_WriteSelect  output  ADDR_W  to register file
- RF_WriteData  output  DATA_W  to register file
- RF_WriteEnable  output  1  to register file

Behaviour:
- Reset (async, rst=1): all RF_* outputs 0, buffer empty, B_Pending=0, B_PendingSelect=0, starve counter 0, FSM=IDLE. Reset mid-operation discards any held B result; the multi-cycle unit must reissue it.
- FSM states:
  - IDLE: buffer empty.
  - HELD: buffer full, waiting for a free slot.
  - FORCE: starvation reached.
- Transitions:
  - IDLE -> HELD on B accept.
  - HELD -> IDLE when B is granted.
  - HELD -> FORCE when counter == STARVE_LIMIT.
  - FORCE -> IDLE unconditionally after one cycle.
- Grant rules, evaluated each cycle:
  - FORCE: grant B; A_Ready=0.
  - Otherwise, if A_Valid: grant A; A_Ready=1.
  - Otherwise, if buffer held: grant B.
  - A_Ready=1 whenever the state is not FORCE, even if A_Valid=0.
- Starve counter:
  - Increments in HELD on each cycle where A is granted over B.
  - Clears on B grant or when returning to IDLE.
  - Width 4 bits; saturates at STARVE_LIMIT.
- B_Ready = (state == IDLE); no same-cycle bypass.
- B accept-to-write latency is at least 2 cycles:
  - cycle n: accept
  - cycle n+1: earliest grant
  - cycle n+2: RF_* valid, RF captures at end of n+2
- Output latency: RF_* are registered from the grant in cycle t, driven during t+1. A latency is 1 cycle.
- No grant: RF_WriteEnable=0, RF_WriteSelect/RF_WriteData hold their previous values.
- Same destination for A and B in the same cycle: A wins, B stays held. The hazard unit must use B_Pending/B_PendingSelect to avoid a younger A write being overwritten later.
- B_Valid while buffer full: ignored. The source must hold the request until B_Ready.

Optional Feature:
- Macro: RF_ZERO_GUARD_EN.
- Defined: any grant whose select is 0 drives RF_WriteEnable=0, while the handshake still completes and the buffer still empties.
- Undefined: writes to register 0 pass through unchanged.

Decomposition:
- Shared package rf_pkg:
  - DATA_W, ADDR_W
  - FSM state enum (IDLE, HELD, FORCE), 2-bit encoding 0/1/2
  - grant-source encoding (NONE, A, B)
- Natural sub-module: rf_hold_buffer, the one-entry B select/data register with load/clear and pending flag.

Test Plan:
- Reset: assert rst mid-run with the buffer full -> RF_WriteEnable=0, B_Pending=0, B_Ready=1 immediately; no write after release.
- A only: A_Valid=1, sel=5, data=0xDEADBEEF at cycle t -> A_Ready=1 at t; RF_WriteEnable=1, sel=5, data=0xDEADBEEF during t+1.
- B only: B sel=7, data=0x12 accepted at n, A idle -> B_Pending=1, B_PendingSelect=7 at n+1; RF write of 7/0x12 during n+2; B_Ready=1 again at n+2.
- Conflict: B held, A and B both target register 3 -> A write first; B_PendingSelect=3 stays asserted until the B write lands.
- Starvation: A_Valid=1 continuously, B held, STARVE_LIMIT=4 -> four A grants, then FORCE with A_Ready=0 for one cycle; B written next cycle, then A resumes.
- Zero guard (RF_ZERO_GUARD_EN defined): A sel=0, data=0xFF -> A_Ready=1 and RF_WriteEnable=0. Undefined: RF_WriteEnable=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grantSrc_t;

endpackage

// File: rtl/rf_hold_buffer.sv
// One-entry holding register for the multi-cycle unit's result.
// The select reads as 0 whenever the entry is empty.
module rf_hold_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] loadSelect,
    input  logic [DATA_W-1:0] loadData,
    output logic              pending,
    output logic [ADDR_W-1:0] holdSelect,
    output logic [DATA_W-1:0] holdData
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            holdSelect <= '0;
            holdData   <= '0;
        end else if (load) begin
            pending    <= 1'b1;
            holdSelect <= loadSelect;
            holdData   <= loadData;
        end else if (clear) begin
            pending    <= 1'b0;
            holdSelect <= '0;
            holdData   <= '0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between S3 writeback (A) and a buffered multi-cycle unit (B).
// Define RF_ZERO_GUARD_EN to suppress the write enable for any grant targeting register 0.
module rf_write_arbiter #(
    parameter int unsigned DATA_W       = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W       = rf_pkg::ADDR_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [ADDR_W-1:0] A_WriteSelect,
    input  logic [DATA_W-1:0] A_WriteData,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_WriteSelect,
    input  logic [DATA_W-1:0] B_WriteData,
    output logic              B_Pending,
    output logic [ADDR_W-1:0] B_PendingSelect,
    output logic [ADDR_W-1:0] RF_WriteSelect,
    output logic [DATA_W-1:0] RF_WriteData,
    output logic              RF_WriteEnable
);

    import rf_pkg::*;

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

    arbState_t         state, stateNext;
    grantSrc_t         grant;
    logic [3:0]        starveCnt, starveNext;
    logic              bufLoad, bufClear, zeroBlock;
    logic [DATA_W-1:0] holdData;
    logic [ADDR_W-1:0] wrSelect;
    logic [DATA_W-1:0] wrData;
    logic              wrEnable;

    rf_hold_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_holdBuffer (
        .clk       (clk),
        .rst       (rst),
        .load      (bufLoad),
        .clear     (bufClear),
        .loadSelect(B_WriteSelect),
        .loadData  (B_WriteData),
        .pending   (B_Pending),
        .holdSelect(B_PendingSelect),
        .holdData  (holdData)
    );

    // A has fixed priority except in FORCE, where it is back-pressured for one cycle.
    always_comb begin
        grant   = GRANT_NONE;
        A_Ready = 1'b1;
        if (state == FORCE) begin
            grant   = GRANT_B;
            A_Ready = 1'b0;
        end else if (A_Valid) begin
            grant = GRANT_A;
        end else if (state == HELD) begin
            grant = GRANT_B;
        end
    end

    assign B_Ready  = (state == IDLE);
    assign bufLoad  = B_Ready && B_Valid;
    assign bufClear = (grant == GRANT_B);

    always_comb begin
        stateNext  = state;
        starveNext = starveCnt;
        case (state)
            IDLE: begin
                starveNext = 4'd0;
                if (bufLoad) begin
                    stateNext = HELD;
                end
            end
            HELD: begin
                if (grant == GRANT_B) begin
                    stateNext  = IDLE;
                    starveNext = 4'd0;
                end else begin
                    starveNext = (starveCnt >= StarveLim) ? StarveLim : starveCnt + 4'd1;
                    // Force on the grant that reaches the limit, so B waits exactly LIMIT A writes.
                    if (starveNext == StarveLim) begin
                        stateNext = FORCE;
                    end
                end
            end
            FORCE: begin
                stateNext  = IDLE;
                starveNext = 4'd0;
            end
            default: begin
                stateNext  = IDLE;
                starveNext = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
        end
    end

`ifdef RF_ZERO_GUARD_EN
    assign zeroBlock = (wrSelect == '0);
`else
    assign zeroBlock = 1'b0;
`endif

    assign wrSelect = (grant == GRANT_A) ? A_WriteSelect : B_PendingSelect;
    assign wrData   = (grant == GRANT_A) ? A_WriteData : holdData;
    assign wrEnable = (grant != GRANT_NONE) && !zeroBlock;

    // Select/data hold their last value on idle cycles; only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RF_WriteEnable <= 1'b0;
            RF_WriteSelect <= '0;
            RF_WriteData   <= '0;
        end else begin
            RF_WriteEnable <= wrEnable;
            if (grant != GRANT_NONE) begin
                RF_WriteSelect <= wrSelect;
                RF_WriteData   <= wrData;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; expected RF writes are queued at drive time and
// checked in order as they appear on the register-file port.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        A_Valid;
    logic        A_Ready;
    logic [4:0]  A_WriteSelect;
    logic [31:0] A_WriteData;
    logic        B_Valid;
    logic        B_Ready;
    logic [4:0]  B_WriteSelect;
    logic [31:0] B_WriteData;
    logic        B_Pending;
    logic [4:0]  B_PendingSelect;
    logic [4:0]  RF_WriteSelect;
    logic [31:0] RF_WriteData;
    logic        RF_WriteEnable;

    int compared   = 0;
    int mismatched = 0;

    logic [36:0] expQ[$];

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .A_Valid        (A_Valid),
        .A_Ready        (A_Ready),
        .A_WriteSelect  (A_WriteSelect),
        .A_WriteData    (A_WriteData),
        .B_Valid        (B_Valid),
        .B_Ready        (B_Ready),
        .B_WriteSelect  (B_WriteSelect),
        .B_WriteData    (B_WriteData),
        .B_Pending      (B_Pending),
        .B_PendingSelect(B_PendingSelect),
        .RF_WriteSelect (RF_WriteSelect),
        .RF_WriteData   (RF_WriteData),
        .RF_WriteEnable (RF_WriteEnable)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushWrite(input logic [4:0] sel, input logic [31:0] data);
        expQ.push_back({sel, data});
    endtask

    // Scoreboard: every RF write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && RF_WriteEnable) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", {27'd0, RF_WriteSelect, RF_WriteData}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("rf_write", {27'd0, RF_WriteSelect, RF_WriteData}, {27'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        A_Valid = 1'b0; A_WriteSelect = '0; A_WriteData = '0;
        B_Valid = 1'b0; B_WriteSelect = '0; B_WriteData = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_we", RF_WriteEnable, 1'b0);
        check("rst_sel", RF_WriteSelect, 5'd0);
        check("rst_data", RF_WriteData, 32'd0);
        check("rst_pending", B_Pending, 1'b0);
        check("rst_psel", B_PendingSelect, 5'd0);
        check("rst_bready", B_Ready, 1'b1);
        check("rst_aready", A_Ready, 1'b1);
        rst = 1'b0;

        // A only: one-cycle latency
        @(negedge clk);
        A_Valid = 1'b1; A_WriteSelect = 5'd5; A_WriteData = 32'hDEAD_BEEF;
        pushWrite(5'd5, 32'hDEAD_BEEF);
        #1 check("a_only_ready", A_Ready, 1'b1);
        @(negedge clk);
        A_Valid = 1'b0;
        check("a_only_we", RF_WriteEnable, 1'b1);
        @(negedge clk);
        check("a_only_we_drop", RF_WriteEnable, 1'b0);
        check("a_only_sel_hold", RF_WriteSelect, 5'd5);

        // B only: accept at n, pending at n+1, write during n+2
        B_Valid = 1'b1; B_WriteSelect = 5'd7; B_WriteData = 32'h12;
        pushWrite(5'd7, 32'h12);
        #1 check("b_only_bready", B_Ready, 1'b1);
        @(negedge clk);
        B_Valid = 1'b0;
        check("b_only_pending", B_Pending, 1'b1);
        check("b_only_psel", B_PendingSelect, 5'd7);
        check("b_only_bready_busy", B_Ready, 1'b0);
        check("b_only_no_early_we", RF_WriteEnable, 1'b0);
        @(negedge clk);
        check("b_only_we", RF_WriteEnable, 1'b1);
        check("b_only_bready_back", B_Ready, 1'b1);
        check("b_only_pending_clr", B_Pending, 1'b0);
        @(negedge clk);
        check("b_only_we_drop", RF_WriteEnable, 1'b0);

        // Conflict on register 3: A first, B held until its own write
        B_Valid = 1'b1; B_WriteSelect = 5'd3; B_WriteData = 32'hBBBB;
        @(negedge clk);
        B_Valid = 1'b0;
        A_Valid = 1'b1; A_WriteSelect = 5'd3; A_WriteData = 32'hAAAA;
        pushWrite(5'd3, 32'hAAAA);
        pushWrite(5'd3, 32'hBBBB);
        #1 check("conf_aready", A_Ready, 1'b1);
        check("conf_psel", B_PendingSelect, 5'd3);
        @(negedge clk);
        A_Valid = 1'b0;
        check("conf_a_we", RF_WriteEnable, 1'b1);
        check("conf_pending_kept", B_Pending, 1'b1);
        check("conf_psel_kept", B_PendingSelect, 5'd3);
        @(negedge clk);
        check("conf_b_we", RF_WriteEnable, 1'b1);
        check("conf_pending_clr", B_Pending, 1'b0);
        check("conf_psel_clr", B_PendingSelect, 5'd0);
        @(negedge clk);

        // Starvation: B accepted alongside A, then four A grants while held, then FORCE
        A_Valid = 1'b1; A_WriteSelect = 5'd1; A_WriteData = 32'h100;
        B_Valid = 1'b1; B_WriteSelect = 5'd9; B_WriteData = 32'h99;
        pushWrite(5'd1, 32'h100);
        @(negedge clk);
        B_Valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            A_WriteData = 32'h100 + 32'(i);
            pushWrite(5'd1, 32'h100 + 32'(i));
            #1 check("starve_aready", A_Ready, 1'b1);
            check("starve_pending", B_Pending, 1'b1);
            @(negedge clk);
        end
        A_WriteData = 32'h105;
        pushWrite(5'd9, 32'h99);
        #1 check("force_aready", A_Ready, 1'b0);
        check("force_pending", B_Pending, 1'b1);
        @(negedge clk);
        pushWrite(5'd1, 32'h105);
        #1 check("resume_aready", A_Ready, 1'b1);
        check("resume_pending", B_Pending, 1'b0);
        check("force_b_sel", RF_WriteSelect, 5'd9);
        @(negedge clk);
        A_Valid = 1'b0;
        @(negedge clk);

        // Register 0 write
        A_Valid = 1'b1; A_WriteSelect = 5'd0; A_WriteData = 32'hFF;
`ifndef RF_ZERO_GUARD_EN
        pushWrite(5'd0, 32'hFF);
`endif
        #1 check("zero_aready", A_Ready, 1'b1);
        @(negedge clk);
        A_Valid = 1'b0;
`ifdef RF_ZERO_GUARD_EN
        check("zero_we", RF_WriteEnable, 1'b0);
`else
        check("zero_we", RF_WriteEnable, 1'b1);
`endif
        @(negedge clk);

        // Reset with the buffer full discards the held result
        B_Valid = 1'b1; B_WriteSelect = 5'd12; B_WriteData = 32'hC;
        @(negedge clk);
        B_Valid = 1'b0;
        A_Valid = 1'b1; A_WriteSelect = 5'd4; A_WriteData = 32'h44;
        pushWrite(5'd4, 32'h44);
        @(negedge clk);
        A_Valid = 1'b0;
        check("prerst_pending", B_Pending, 1'b1);
        #1 rst = 1'b1;
        #1 check("midrst_we", RF_WriteEnable, 1'b0);
        check("midrst_pending", B_Pending, 1'b0);
        check("midrst_bready", B_Ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_we", RF_WriteEnable, 1'b0);
        end

        check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
